// File: rtl/wsack_pkg.sv
// Shared types for the wait-state acknowledge generator: FSM states and the
// per-channel wait table entry. CW, the wait-count width, lives here because the table types derive from it.
package wsack_pkg;

    localparam int CW = 4;

    typedef logic [CW-1:0] wait_t;

    typedef struct packed {
        wait_t rd;
        wait_t wr;
    } tbl_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STRETCH,
        ST_ACK,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/ack_wait_ctr.sv
// Loadable down-counter with clock enable and zero flag, plus a saturating
// up-count mode; serves as both the wait-state and the timeout counter.
module ack_wait_ctr #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
        end else if (ce) begin
            if (clr) begin
                cnt <= '0;
            end else if (ld) begin
                cnt <= ld_val;
            end else if (dec && (cnt != '0)) begin
                cnt <= cnt - W'(1);
            end else if (inc && (cnt != MAX)) begin
                cnt <= cnt + W'(1);
            end
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wait_state_ack_gen.sv
// Multi-channel bus acknowledge generator: per-channel programmable read/write
// wait states, slave ready-stretch with timeout, abort, pulse or level ack.
module wait_state_ack_gen
    import wsack_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int RD_WAIT   = 3,
    parameter int WR_WAIT   = 0,
    parameter int TMO       = 255,
    parameter int ACK_PULSE = 1,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           ce_i,
    input  logic           stb_i,
    input  logic           we_i,
    input  logic [NCH-1:0] cs_i,
    input  logic           rdy_i,
    input  logic           cfg_we_i,
    input  logic [CHW-1:0] cfg_ch_i,
    input  logic [CW-1:0]  cfg_rd_i,
    input  logic [CW-1:0]  cfg_wr_i,
    output logic           ack_o,
    output logic           err_o,
    output logic           busy_o,
    output logic [CHW-1:0] ch_o
);

    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    tbl_entry_t     tbl [NCH];
    state_t         state;
    state_t         state_nxt;
    logic [CHW-1:0] sel_ch;
    logic [CHW-1:0] ch_q;
    wait_t          ld_val;
    wait_t          wait_cnt;
    logic           wait_zero;
    logic [TW-1:0]  tmo_cnt;
    logic           unused_tmo_zero;
    logic           tmo_hit;
    logic           start;
    logic           err_set;
    logic           ack_q;
    logic           err_q;

    function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] v);
        logic [CHW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) idx = CHW'(i);
        end
        return idx;
    endfunction

    assign sel_ch = lowest_set(cs_i);
    // Read before the table update on the same edge, so a colliding write is not seen.
    assign ld_val = we_i ? tbl[sel_ch].wr : tbl[sel_ch].rd;

    always_ff @(posedge clk_i) begin
        // NOTE: the table is a flop array, so resetting it to defaults is cheap and intended.
        if (rst_i) begin
            for (int i = 0; i < NCH; i++) begin
                tbl[i] <= '{rd: wait_t'(RD_WAIT), wr: wait_t'(WR_WAIT)};
            end
        end else if (cfg_we_i && (int'(cfg_ch_i) < NCH)) begin
            tbl[cfg_ch_i] <= '{rd: cfg_rd_i, wr: cfg_wr_i};
        end
    end

    ack_wait_ctr #(
        .W   (CW),
        .MAX ('1)
    ) u_wait_ctr (
        .clk    (clk_i),
        .rst    (rst_i),
        .ce     (ce_i),
        .clr    (1'b0),
        .ld     (start),
        .ld_val (ld_val),
        .dec    (state == ST_WAIT),
        .inc    (1'b0),
        .cnt    (wait_cnt),
        .zero   (wait_zero)
    );

    ack_wait_ctr #(
        .W   (TW),
        .MAX (TW'(TMO))
    ) u_tmo_ctr (
        .clk    (clk_i),
        .rst    (rst_i),
        .ce     (ce_i),
        .clr    (state != ST_STRETCH),
        .ld     (1'b0),
        .ld_val ('0),
        .dec    (1'b0),
        .inc    ((state == ST_STRETCH) && !rdy_i),
        .cnt    (tmo_cnt),
        .zero   (unused_tmo_zero)
    );

    // The low-ready cycle that would take the count to TMO is the one that times out.
    assign tmo_hit = (TMO != 0) && (tmo_cnt == TW'(TMO - 1));

    always_comb begin
        // NOTE: defaults first on every comb output keep all paths latch-free.
        state_nxt = state;
        start     = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stb_i && (|cs_i)) begin
                    start     = 1'b1;
                    state_nxt = (ld_val != '0) ? ST_WAIT : ST_STRETCH;
                end
            end
            ST_WAIT: begin
                if (!stb_i) begin
                    state_nxt = ST_IDLE;
                end else if ((wait_cnt == CW'(1)) || wait_zero) begin
                    state_nxt = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (!stb_i) begin
                    state_nxt = ST_IDLE;
                end else if (rdy_i) begin
                    state_nxt = ST_ACK;
                end else if (tmo_hit) begin
                    err_set   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_ACK: begin
                if (ACK_PULSE != 0) begin
                    state_nxt = ST_HOLD;
                end else if (!stb_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!stb_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            ch_q  <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else if (ce_i) begin
            state <= state_nxt;
            ack_q <= (state_nxt == ST_ACK);
            err_q <= err_set;
            if (start) ch_q <= sel_ch;
        end
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign busy_o = (state != ST_IDLE);
    assign ch_o   = ch_q;

endmodule
